// File: rtl/lcd_panel_rx_pkg.sv
// Shared opcodes, decoder states and pixel format for the panel-link responder.
package lcd_pkg;

    localparam logic [7:0] CMD_SLPIN  = 8'h10;
    localparam logic [7:0] CMD_SLPOUT = 8'h11;
    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_PASET  = 8'h2B;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;

    localparam int COLOR_W = 16;

    typedef enum logic [2:0] {
        CMD,
        CASET,
        PASET,
        RAMWR,
        SKIP
    } state_t;

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling byte receiver for the 4-wire panel link: synchronizes the lines,
// shifts sda on scl rising edges while cs is low and emits one pulse per byte.
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sda,
    input  logic       scl,
    input  logic       cs,
    input  logic       rs,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_rs
);

    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [NS-1:0] r_sda_sync;
    logic [NS-1:0] r_scl_sync;
    logic [NS-1:0] r_cs_sync;
    logic [NS-1:0] r_rs_sync;
    logic          r_scl_prev;
    logic [2:0]    r_bit_cnt;
    logic [6:0]    r_shift;

    logic w_sda;
    logic w_scl;
    logic w_cs;
    logic w_rs;
    logic w_scl_rise;

    assign w_sda      = r_sda_sync[NS-1];
    assign w_scl      = r_scl_sync[NS-1];
    assign w_cs       = r_cs_sync[NS-1];
    assign w_rs       = r_rs_sync[NS-1];
    assign w_scl_rise = w_scl & ~r_scl_prev;

    // cs and scl reset to their idle-high level so releasing reset cannot fake an edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sda_sync <= '0;
            r_scl_sync <= '1;
            r_cs_sync  <= '1;
            r_rs_sync  <= '0;
            r_scl_prev <= 1'b1;
        end else begin
            r_sda_sync <= {r_sda_sync[NS-2:0], sda};
            r_scl_sync <= {r_scl_sync[NS-2:0], scl};
            r_cs_sync  <= {r_cs_sync[NS-2:0], cs};
            r_rs_sync  <= {r_rs_sync[NS-2:0], rs};
            r_scl_prev <= w_scl;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit_cnt  <= 3'd0;
            r_shift    <= 7'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'd0;
            byte_rs    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (w_cs) begin
                r_bit_cnt <= 3'd0;
            end else if (w_scl_rise) begin
                r_shift   <= {r_shift[5:0], w_sda};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {r_shift, w_sda};
                    byte_rs    <= w_rs;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_panel_rx.sv
// Panel-link responder: decodes controller commands and turns RAMWR data into
// RGB565 pixel writes with window-relative (x, y) coordinates.
module lcd_panel_rx
    import lcd_pkg::*;
#(
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sda,
    input  logic                      scl,
    input  logic                      cs,
    input  logic                      rs,
    output logic                      byte_valid,
    output logic [7:0]                byte_data,
    output logic                      byte_rs,
    output logic                      pix_valid,
    output logic [$clog2(WIDTH)-1:0]  pix_x,
    output logic [$clog2(HEIGHT)-1:0] pix_y,
    output logic [COLOR_W-1:0]        pix_color,
    output logic                      frame_start,
    output logic                      awake,
    output logic                      err
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [15:0]   W16    = 16'(WIDTH);
    localparam logic [15:0]   H16    = 16'(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [XW-1:0] r_sc;
    logic [XW-1:0] r_ec;
    logic [YW-1:0] r_sp;
    logic [YW-1:0] r_ep;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_phase_lo;
    logic [7:0]    r_hi;
    logic [23:0]   r_param;
    logic [1:0]    r_pidx;

    logic          w_cmd_evt;
    logic          w_data_evt;
    logic          w_win_state;
    logic          w_last_param;
    logic [31:0]   w_param;
    logic [15:0]   w_start;
    logic [15:0]   w_end;
    logic [15:0]   w_limit;
    logic          w_in_range;

    spi_byte_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_spi (
        .clk       (clk),
        .reset     (reset),
        .sda       (sda),
        .scl       (scl),
        .cs        (cs),
        .rs        (rs),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_rs   (byte_rs)
    );

    assign w_cmd_evt    = byte_valid & ~byte_rs;
    assign w_data_evt   = byte_valid & byte_rs;
    assign w_win_state  = (r_state == CASET) || (r_state == PASET);
    assign w_last_param = w_data_evt && w_win_state && (r_pidx == 2'd3);
    assign w_param      = {r_param, byte_data};
    assign w_start      = w_param[31:16];
    assign w_end        = w_param[15:0];
    assign w_limit      = (r_state == CASET) ? W16 : H16;
    assign w_in_range   = (w_start <= w_end) && (w_end < w_limit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= CMD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A command byte always restarts decoding, whatever state was active
    always_comb begin
        w_state_nxt = r_state;
        if (w_cmd_evt) begin
            case (byte_data)
                CMD_CASET:             w_state_nxt = CASET;
                CMD_PASET:             w_state_nxt = PASET;
                CMD_RAMWR:             w_state_nxt = RAMWR;
                CMD_SLPIN, CMD_SLPOUT: w_state_nxt = CMD;
                default:               w_state_nxt = SKIP;
            endcase
        end else if (w_last_param) begin
            w_state_nxt = CMD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sc        <= '0;
            r_ec        <= X_LAST;
            r_sp        <= '0;
            r_ep        <= Y_LAST;
            r_x         <= '0;
            r_y         <= '0;
            r_phase_lo  <= 1'b0;
            r_hi        <= 8'd0;
            r_param     <= 24'd0;
            r_pidx      <= 2'd0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_color   <= '0;
            frame_start <= 1'b0;
            awake       <= 1'b0;
            err         <= 1'b0;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            err         <= 1'b0;
            if (w_cmd_evt) begin
                r_pidx     <= 2'd0;
                r_phase_lo <= 1'b0;
                case (byte_data)
                    CMD_RAMWR: begin
                        r_x         <= r_sc;
                        r_y         <= r_sp;
                        frame_start <= 1'b1;
                    end
                    CMD_SLPOUT: awake <= 1'b1;
                    CMD_SLPIN:  awake <= 1'b0;
                    default: ;
                endcase
            end else if (w_data_evt) begin
                case (r_state)
                    CASET, PASET: begin
                        r_param <= {r_param[15:0], byte_data};
                        r_pidx  <= r_pidx + 2'd1;
                        if (r_pidx == 2'd3) begin
                            if (!w_in_range) begin
                                err <= 1'b1;
                            end else if (r_state == CASET) begin
                                r_sc <= w_start[XW-1:0];
                                r_ec <= w_end[XW-1:0];
                            end else begin
                                r_sp <= w_start[YW-1:0];
                                r_ep <= w_end[YW-1:0];
                            end
                        end
                    end
                    RAMWR: begin
                        if (!r_phase_lo) begin
                            r_hi       <= byte_data;
                            r_phase_lo <= 1'b1;
                        end else begin
                            r_phase_lo <= 1'b0;
                            pix_valid  <= 1'b1;
                            pix_x      <= r_x;
                            pix_y      <= r_y;
                            pix_color  <= {r_hi, byte_data};
                            // Raster advance inside the window, wrapping to the top-left corner
                            if (r_x == r_ec) begin
                                r_x <= r_sc;
                                r_y <= (r_y == r_ep) ? r_sp : r_y + YW'(1);
                            end else begin
                                r_x <= r_x + XW'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_panel_rx.sv
// Directed bench for lcd_panel_rx on a reduced 40x12 panel, with a command-level
// reference model and literal spot checks.
module tb_lcd_panel_rx;

    localparam int W  = 40;
    localparam int H  = 12;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic          clk = 1'b0;
    logic          reset;
    logic          sda, scl, cs, rs;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_rs;
    logic          pix_valid;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [15:0]   pix_color;
    logic          frame_start, awake, err;

    always #5 clk = ~clk;

    lcd_panel_rx #(.WIDTH(W), .HEIGHT(H), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sda(sda), .scl(scl), .cs(cs), .rs(rs),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_rs(byte_rs),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .frame_start(frame_start), .awake(awake), .err(err)
    );

    typedef struct { int x; int y; int c; } pix_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    pix_t exp_pix[$];
    int   exp_byte[$];
    int   exp_fs, exp_err;
    pix_t cap[$];
    int   dut_fs, dut_err, dut_bytes;

    int   m_sc, m_ec, m_sp, m_ep;
    int   f_sc, f_ec, f_sp, f_ep, m_n;
    int   m_mode;
    int   m_params[$];
    bit   m_hi_v;
    int   m_hi;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sc = 0; m_ec = W - 1; m_sp = 0; m_ep = H - 1;
        m_mode = 0; m_hi_v = 0; m_n = 0;
        m_params.delete();
        exp_pix.delete(); exp_byte.delete();
        exp_fs = 0; exp_err = 0;
    endtask

    // Command semantics: pixels are placed by their index within the RAMWR burst
    task automatic model_byte(input bit r, input logic [7:0] d);
        int s, e, lim, cols, rows;
        pix_t p;
        exp_byte.push_back({23'd0, r, d});
        if (!r) begin
            m_params.delete();
            m_hi_v = 0;
            case (d)
                8'h2A: m_mode = 1;
                8'h2B: m_mode = 2;
                8'h2C: begin
                    m_mode = 3; m_n = 0; exp_fs++;
                    f_sc = m_sc; f_ec = m_ec; f_sp = m_sp; f_ep = m_ep;
                end
                default: m_mode = 0;
            endcase
        end else if (m_mode == 1 || m_mode == 2) begin
            m_params.push_back(int'(d));
            if (m_params.size() == 4) begin
                s   = m_params[0] * 256 + m_params[1];
                e   = m_params[2] * 256 + m_params[3];
                lim = (m_mode == 1) ? W : H;
                if (s <= e && e < lim) begin
                    if (m_mode == 1) begin m_sc = s; m_ec = e; end
                    else begin m_sp = s; m_ep = e; end
                end else begin
                    exp_err++;
                end
                m_mode = 0;
                m_params.delete();
            end
        end else if (m_mode == 3) begin
            if (!m_hi_v) begin
                m_hi = int'(d); m_hi_v = 1;
            end else begin
                cols = f_ec - f_sc + 1;
                rows = f_ep - f_sp + 1;
                p.x = f_sc + m_n % cols;
                p.y = f_sp + (m_n / cols) % rows;
                p.c = m_hi * 256 + int'(d);
                exp_pix.push_back(p);
                m_n++; m_hi_v = 0;
            end
        end
    endtask

    task automatic send_byte(input bit r, input logic [7:0] d);
        model_byte(r, d);
        cs = 1'b0;
        rs = r;
        for (int i = 7; i >= 0; i--) begin
            sda = d[i];
            repeat (2) @(negedge clk);
            scl = 1'b1;
            repeat (2) @(negedge clk);
            scl = 1'b0;
        end
    endtask

    task automatic send_pix(input logic [15:0] c);
        send_byte(1'b1, c[15:8]);
        send_byte(1'b1, c[7:0]);
    endtask

    task automatic send_param4(input logic [7:0] a, b, c, d);
        send_byte(1'b1, a); send_byte(1'b1, b); send_byte(1'b1, c); send_byte(1'b1, d);
    endtask

    task automatic idle();
        repeat (12) @(negedge clk);
        check("pix_left", exp_pix.size(), 0);
        check("byte_left", exp_byte.size(), 0);
        check("fs_left", exp_fs, 0);
        check("err_left", exp_err, 0);
    endtask

    task automatic check_pix(input string name, input int idx, input int x, y, c);
        if (idx < cap.size()) begin
            check({name, "_x"}, cap[idx].x, x);
            check({name, "_y"}, cap[idx].y, y);
            check({name, "_c"}, cap[idx].c, c);
        end else begin
            check({name, "_present"}, cap.size(), idx + 1);
        end
    endtask

    // Per-cycle comparison of every DUT event against the model
    always @(negedge clk) begin
        pix_t p, q;
        int   eb;
        if (reset) begin
            if (byte_valid) begin
                dut_bytes++;
                check("byte_expected", exp_byte.size() > 0, 1);
                if (exp_byte.size() > 0) begin
                    eb = exp_byte.pop_front();
                    check("byte", {23'd0, byte_rs, byte_data}, eb);
                end
            end
            if (pix_valid) begin
                p.x = int'(pix_x); p.y = int'(pix_y); p.c = int'(pix_color);
                cap.push_back(p);
                check("pix_expected", exp_pix.size() > 0, 1);
                if (exp_pix.size() > 0) begin
                    q = exp_pix.pop_front();
                    check("pix_x", p.x, q.x);
                    check("pix_y", p.y, q.y);
                    check("pix_color", p.c, q.c);
                end
            end
            if (frame_start) begin
                dut_fs++;
                check("fs_expected", exp_fs > 0, 1);
                if (exp_fs > 0) exp_fs--;
            end
            if (err) begin
                dut_err++;
                check("err_expected", exp_err > 0, 1);
                if (exp_err > 0) exp_err--;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_valid"}, byte_valid, 0);
        check({tag, "_byte_data"}, byte_data, 0);
        check({tag, "_byte_rs"}, byte_rs, 0);
        check({tag, "_pix_valid"}, pix_valid, 0);
        check({tag, "_pix_x"}, pix_x, 0);
        check({tag, "_pix_y"}, pix_y, 0);
        check({tag, "_pix_color"}, pix_color, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_awake"}, awake, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        int base, fs0, err0, by0;
        cs = 1'b1; scl = 1'b0; sda = 1'b0; rs = 1'b0; reset = 1'b0;
        dut_fs = 0; dut_err = 0; dut_bytes = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Default window, two pixels
        base = cap.size();
        send_byte(1'b0, 8'h2C);
        send_pix(16'hF800);
        send_pix(16'h07E0);
        idle();
        check("t1_fs", dut_fs, 1);
        check_pix("t1_p0", base, 0, 0, 16'hF800);
        check_pix("t1_p1", base + 1, 1, 0, 16'h07E0);

        // Whole frame plus one wrapping pixel
        base = cap.size();
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i <= W * H; i++) send_pix(16'(i));
        idle();
        check("frame_count", cap.size() - base, W * H + 1);
        check_pix("frame_last", base + W * H - 1, W - 1, H - 1, W * H - 1);
        check_pix("frame_wrap", base + W * H, 0, 0, W * H);

        // Rejected windows, then an aborted partial CASET
        err0 = dut_err;
        send_byte(1'b0, 8'h2A); send_param4(8'd0, 8'd20, 8'd0, 8'd10);
        send_byte(1'b0, 8'h2A); send_param4(8'd0, 8'(W), 8'd0, 8'(W + 1));
        send_byte(1'b0, 8'h2A); send_byte(1'b1, 8'd0); send_byte(1'b1, 8'd5);
        base = cap.size();
        send_byte(1'b0, 8'h2C);
        send_pix(16'h1234);
        idle();
        check("err_count", dut_err - err0, 2);
        check_pix("after_err", base, 0, 0, 16'h1234);

        // Fragment discarded by cs, then SLPOUT
        by0 = dut_bytes;
        cs = 1'b0; rs = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sda = i[0];
            repeat (2) @(negedge clk); scl = 1'b1;
            repeat (2) @(negedge clk); scl = 1'b0;
        end
        cs = 1'b1;
        repeat (6) @(negedge clk);
        send_byte(1'b0, 8'h11);
        idle();
        check("frag_bytes", dut_bytes - by0, 1);
        check("awake_on", awake, 1);

        // Windowed burst with wrap
        send_byte(1'b0, 8'h2A); send_param4(8'd0, 8'd10, 8'd0, 8'd11);
        send_byte(1'b0, 8'h2B); send_param4(8'd0, 8'd5, 8'd0, 8'd6);
        base = cap.size();
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 5; i++) send_pix(16'hA000 + 16'(i));
        idle();
        check_pix("win0", base, 10, 5, 16'hA000);
        check_pix("win1", base + 1, 11, 5, 16'hA001);
        check_pix("win2", base + 2, 10, 6, 16'hA002);
        check_pix("win3", base + 3, 11, 6, 16'hA003);
        check_pix("win4", base + 4, 10, 5, 16'hA004);

        // Half pixel dropped by a new RAMWR
        fs0 = dut_fs; base = cap.size();
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'hEE);
        send_byte(1'b0, 8'h2C);
        send_pix(16'h5A5A);
        idle();
        check("abort_fs", dut_fs - fs0, 2);
        check("abort_pix", cap.size() - base, 1);
        check_pix("abort_p0", base, 10, 5, 16'h5A5A);

        // Reset in the middle of a RAMWR burst
        send_byte(1'b0, 8'h2C);
        send_pix(16'hBEEF);
        send_pix(16'hCAFE);
        send_byte(1'b1, 8'hAB);
        idle();
        cs = 1'b1;
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        base = cap.size();
        send_byte(1'b0, 8'h2C);
        send_pix(16'h0F0F);
        send_pix(16'h0F10);
        idle();
        check_pix("post_rst0", base, 0, 0, 16'h0F0F);
        check_pix("post_rst1", base + 1, 1, 0, 16'h0F10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_panel_rx.md
Name: lcd_panel_rx

Overview:
- Responder end of the panel serial link: deserializes the 4-wire stream (sda, scl, cs, rs) driven by the LCD controller and decodes the command set it issues.
- Turns RAMWR pixel bytes into RGB565 pixel writes with (x, y) coordinates, for a framebuffer or simulation panel model.
- Sits in benches and in the console's loopback/capture path.
- Runs on its own system clock and oversamples the serial lines.

Parameters:
- WIDTH, 320, panel columns; default column window 0..WIDTH-1.
- HEIGHT, 240, panel rows; default page window 0..HEIGHT-1.
- SYNC_STAGES, 2, synchronizer flops on sda/scl/cs/rs (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 4x the scl frequency.
- reset  in  1  asynchronous, active-low reset.
- sda  in  1  serial data, MSB first, sampled on scl rising edge.
- scl  in  1  serial clock.
- cs  in  1  chip select, active low; high frames/aborts a byte.
- rs  in  1  0 = command byte, 1 = data byte; sampled with bit 0.
- byte_valid  out  1  one-cycle pulse per completed byte.
- byte_data  out  8  last completed byte.
- byte_rs  out  1  rs of last completed byte.
- pix_valid  out  1  one-cycle pulse per completed pixel.
- pix_x  out  $clog2(WIDTH)  pixel column.
- pix_y  out  $clog2(HEIGHT)  pixel row.
- pix_color  out  16  {R5,G6,B5}.
- frame_start  out  1  one-cycle pulse when RAMWR (0x2C) is decoded.
- awake  out  1  set by SLPOUT (0x11), cleared by SLPIN (0x10).
- err  out  1  one-cycle pulse on a rejected window command.

Behaviour:
Reset (reset low, async) values:
- All pulses 0; byte_data 0; byte_rs 0; pix_x/pix_y/pix_color 0; awake 0.
- Window: cols 0..WIDTH-1, rows 0..HEIGHT-1.
- FSM in CMD; bit counter 0; shift register 0.

Serial front end:
- sda/scl/cs/rs pass through SYNC_STAGES flops.
- A rising edge of synced scl while synced cs = 0 shifts in sda.
- On the 8th bit: byte_valid pulses the next clk, with rs sampled alongside that bit.
- Latency is SYNC_STAGES + 1 clk from the scl edge.
- Synced cs high at any time clears the bit counter; a partial byte is discarded with no pulse.

Decoder FSM (one transition per completed byte):
- CMD: rs = 0 bytes decode as follows.
  - 0x2A -> CASET, param index 0.
  - 0x2B -> PASET, param index 0.
  - 0x2C -> RAMWR: x = SC, y = SP, phase = hi, frame_start pulses.
  - 0x11 -> awake = 1.
  - 0x10 -> awake = 0.
  - Other commands -> SKIP.
  - rs = 1 bytes in CMD are ignored.
- CASET/PASET: collect 4 data bytes {start_hi, start_lo, end_hi, end_lo} into a staging register.
  - After the 4th byte, commit if start <= end and end < WIDTH (CASET) or HEIGHT (PASET); otherwise leave the window unchanged and pulse err.
  - Then return to CMD.
- RAMWR: phase hi latches the byte as color[15:8]; phase lo forms the pixel.
  - pix_valid pulses the clk after the lo byte's byte_valid, carrying the current x, y and color.
  - Then x advances: x = EC -> x = SC and y advances; y = EP -> y = SP (wrap, no stall).
- SKIP: swallow data bytes.
- Any rs = 0 byte in any state aborts the current state and is decoded as a fresh command in the same cycle.
  - A half pixel pending in RAMWR is dropped without a pix_valid.
  - CASET/PASET with fewer than 4 params: staging is discarded and no commit occurs.
- Window changes take effect at the next RAMWR only; an active RAMWR keeps its counters.

Widths:
- Params are 16-bit; only the low $clog2(WIDTH/HEIGHT) bits drive the counters, after the range check passes.

Decomposition:
- Package lcd_pkg holds:
  - Command opcodes (CMD_SLPIN 8'h10, CMD_SLPOUT 8'h11, CMD_CASET 8'h2A, CMD_PASET 8'h2B, CMD_RAMWR 8'h2C).
  - FSM state enum (CMD, CASET, PASET, RAMWR, SKIP).
  - The RGB565 color width.
- Sub-module spi_byte_rx: synchronizers, edge detect, shift register, cs abort.
  - Outputs byte_valid/byte_data/byte_rs.
- lcd_panel_rx instantiates it and holds the decoder FSM and address counters.

Test Plan:
- Reset, then 0x2C then bytes F8,00,07,E0 -> frame_start; pixels (0,0)=F800, (1,0)=07E0.
- CASET 0,10,0,11; PASET 0,5,0,6; RAMWR + 5 pixels -> coords (10,5),(11,5),(10,6),(11,6),(10,5).
- Full 320x240 frame of 76800 pixels, then a 76801st pixel -> last pixel at (319,239); the extra pixel wraps to (0,0).
- CASET 0,20,0,10 (start>end) and CASET 1,64,1,65 (end=321) -> err pulses twice; a subsequent RAMWR starts at (0,0).
- cs high after 5 bits of a byte, then a full 0x11 -> no byte_valid for the fragment; awake = 1.
- RAMWR, one hi byte, then command 0x2C -> no pix_valid; second frame_start; next pixel at (SC,SP).
- reset asserted mid-RAMWR -> all outputs return to reset values immediately; the window reverts to the defaults.
